// File: rtl/mii_frame_scheduler.sv
// Round-robin frame scheduler for the MII generator. Picks one of N_REQ frame
// sources, latches its frame configuration, drives the generator enable and a
// one-hot register-mux select, and watches txValid to count completed frames.
// A stalled generator is aborted after TIMEOUT_CYCLES in either wait state.
module mii_frame_scheduler #(
   parameter int unsigned N_REQ            = 4,
   parameter int unsigned PAYLOAD_MAX_SIZE = 1500,
   parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
   input  logic                clk,
   input  logic                i_rst_n,
   input  logic [N_REQ-1:0]    i_req,
   input  logic [16*N_REQ-1:0] i_payload_length,
   input  logic [8*N_REQ-1:0]  i_mode,
   input  logic [8*N_REQ-1:0]  i_intergap,
   input  logic                i_gen_txvalid,
   output logic [N_REQ-1:0]    o_grant,
   output logic [15:0]         o_gen_payload_length,
   output logic [7:0]          o_gen_mode,
   output logic [7:0]          o_gen_intergap,
   output logic                o_gen_run,
   output logic [N_REQ-1:0]    o_ack,
   output logic                o_done,
   output logic                o_err,
   output logic                o_busy,
   output logic [31:0]         o_frame_count
);

   localparam int unsigned PtrW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [15:0] WaitLast = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StWaitStart,
      StWaitEnd
   } state_e;

   state_e            state_q, state_d;
   logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [N_REQ-1:0]  owner_q, owner_d;
   logic              rejected_q, rejected_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              busy_q;
   logic              run_q, run_d;
   logic [15:0]       len_q, len_d;
   logic [7:0]        mode_q, mode_d;
   logic [7:0]        gap_q, gap_d;
   logic [31:0]       count_q, count_d;
   logic [15:0]       wait_q, wait_d;

   logic [N_REQ-1:0]  arb_req;
   logic              arb_found;
   logic [PtrW-1:0]   arb_idx;
   logic [PtrW-1:0]   arb_k;
   logic [PtrW-1:0]   arb_next;
   logic [N_REQ-1:0]  arb_onehot;
   logic [15:0]       sel_len;
   logic [7:0]        sel_mode;
   logic [7:0]        sel_gap;
   logic              do_grant;

   // The granted source's own request is ignored while its GRANT cycle is live.
   always_comb begin
      arb_req = i_req;
      if (state_q == StGrant) begin
         arb_req = i_req & ~owner_q;
      end
   end

   // Round-robin search from rr_ptr, wrapping; first set request wins.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_k     = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         arb_k = PtrW'((32'(rr_ptr_q) + i) % N_REQ);
         if (!arb_found && arb_req[arb_k]) begin
            arb_found = 1'b1;
            arb_idx   = arb_k;
         end
      end
      arb_next   = PtrW'((32'(arb_idx) + 1) % N_REQ);
      arb_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << arb_idx;
   end

   // Select the winning source's frame configuration.
   always_comb begin
      sel_len  = '0;
      sel_mode = '0;
      sel_gap  = '0;
      for (int unsigned j = 0; j < N_REQ; j++) begin
         if (arb_idx == PtrW'(j)) begin
            sel_len  = i_payload_length[16*j +: 16];
            sel_mode = i_mode[8*j +: 8];
            sel_gap  = i_intergap[8*j +: 8];
         end
      end
   end

   // Next-state and registered-output logic; every entry to GRANT goes through do_grant.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      rejected_d = rejected_q;
      grant_d    = grant_q;
      ack_d      = '0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      run_d      = run_q;
      len_d      = len_q;
      mode_d     = mode_q;
      gap_d      = gap_q;
      count_d    = count_q;
      wait_d     = wait_q;
      do_grant   = 1'b0;

      case (state_q)
         StIdle: begin
            if (|i_req) begin
               do_grant = 1'b1;
            end
         end
         StGrant: begin
            if (rejected_q) begin
               if (|arb_req) begin
                  do_grant = 1'b1;
               end else begin
                  state_d = StIdle;
                  grant_d = '0;
                  run_d   = 1'b0;
               end
            end else begin
               state_d = StWaitStart;
               wait_d  = '0;
            end
         end
         StWaitStart: begin
            // A txValid edge takes priority over an expiring timeout.
            if (i_gen_txvalid) begin
               state_d = StWaitEnd;
               wait_d  = '0;
            end else if (wait_q == WaitLast) begin
               state_d = StIdle;
               err_d   = 1'b1;
               run_d   = 1'b0;
               grant_d = '0;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         StWaitEnd: begin
            if (!i_gen_txvalid) begin
               done_d  = 1'b1;
               count_d = count_q + 32'd1;
               if (|i_req) begin
                  // Back-to-back: run stays high so the generator keeps its gap timing.
                  do_grant = 1'b1;
               end else begin
                  state_d = StIdle;
                  run_d   = 1'b0;
                  grant_d = '0;
               end
            end else if (wait_q == WaitLast) begin
               state_d = StIdle;
               err_d   = 1'b1;
               run_d   = 1'b0;
               grant_d = '0;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + 16'd1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (do_grant) begin
         state_d  = StGrant;
         rr_ptr_d = arb_next;
         owner_d  = arb_onehot;
         ack_d    = arb_onehot;
         len_d    = sel_len;
         mode_d   = sel_mode;
         gap_d    = sel_gap;
         if (32'(sel_len) > PAYLOAD_MAX_SIZE) begin
            // Rejected frame: acknowledged but never selected; run is left untouched.
            rejected_d = 1'b1;
            err_d      = 1'b1;
            grant_d    = '0;
         end else begin
            rejected_d = 1'b0;
            grant_d    = arb_onehot;
            run_d      = 1'b1;
         end
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         owner_q    <= '0;
         rejected_q <= 1'b0;
         grant_q    <= '0;
         ack_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         run_q      <= 1'b0;
         len_q      <= '0;
         mode_q     <= '0;
         gap_q      <= '0;
         count_q    <= '0;
         wait_q     <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         owner_q    <= owner_d;
         rejected_q <= rejected_d;
         grant_q    <= grant_d;
         ack_q      <= ack_d;
         done_q     <= done_d;
         err_q      <= err_d;
         busy_q     <= (state_d != StIdle);
         run_q      <= run_d;
         len_q      <= len_d;
         mode_q     <= mode_d;
         gap_q      <= gap_d;
         count_q    <= count_d;
         wait_q     <= wait_d;
      end
   end

   assign o_grant              = grant_q;
   assign o_ack                = ack_q;
   assign o_done               = done_q;
   assign o_err                = err_q;
   assign o_busy               = busy_q;
   assign o_gen_run            = run_q;
   assign o_gen_payload_length = len_q;
   assign o_gen_mode           = mode_q;
   assign o_gen_intergap       = gap_q;
   assign o_frame_count        = count_q;

endmodule

// File: doc/mii_frame_scheduler.md
# mii_frame_scheduler

Round-robin frame scheduler for the MII generator. Arbitrates among N_REQ frame sources, latches the winner's frame configuration (payload length, padding mode, inter-packet gap), and drives the generator's configuration inputs plus a one-hot select for the top-level frame-register mux. It holds the selection stable from grant until the generator's `txValid` falls, counts completed frames, and recovers from a stalled generator with a timeout.

## Interface
- N_REQ, 4, number of requesters (2..8)
- PAYLOAD_MAX_SIZE, 1500, largest accepted payload length in bytes
- TIMEOUT_CYCLES, 1024, cycles allowed in each wait state before abort (≥ 2)
- clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req  in  N_REQ  per-source frame request (level)
- i_payload_length  in  16*N_REQ  per-source payload length, source k at [16k+:16]
- i_mode  in  8*N_REQ  per-source generator mode, source k at [8k+:8]
- i_intergap  in  8*N_REQ  per-source inter-packet gap, source k at [8k+:8]
- i_gen_txvalid  in  1  generator `o_txValid`
- o_grant  out  N_REQ  one-hot register-mux select, held for the whole frame
- o_gen_payload_length  out  16  latched length to the generator
- o_gen_mode  out  8  latched mode to the generator
- o_gen_intergap  out  8  latched gap to the generator
- o_gen_run  out  1  generator enable; the top-level ANDs it into the generator reset
- o_ack  out  N_REQ  one-cycle pulse to the granted source
- o_done  out  1  one-cycle pulse when a frame completes
- o_err  out  1  one-cycle pulse on reject or timeout
- o_busy  out  1  high in every state except IDLE
- o_frame_count  out  32  completed-frame count, wraps at 2^32

## Operation
- States: IDLE, GRANT, WAIT_START, WAIT_END.
- IDLE
  - o_gen_run = 0 and o_grant = 0.
  - If any i_req is set, go to GRANT.
- Arbitration (evaluated on entry to GRANT)
  - Search starts at rr_ptr and wraps. The first set bit wins, giving index g.
  - rr_ptr ← (g+1) mod N_REQ.
- GRANT (1 cycle)
  - Latch source g's length/mode/intergap into the o_gen_* registers.
  - o_grant = onehot(g); o_ack[g] = 1.
  - If length > PAYLOAD_MAX_SIZE, the frame is rejected:
    - o_err = 1, o_grant cleared, rr_ptr still advances.
    - o_gen_run keeps its previous value.
    - Go to IDLE if no other request is pending, else GRANT.
  - Otherwise o_gen_run = 1 and go to WAIT_START.
- WAIT_START
  - On i_gen_txvalid = 1, go to WAIT_END.
- WAIT_END
  - On i_gen_txvalid = 0:
    - o_done = 1 and o_frame_count += 1.
    - Go to GRANT if any i_req is set (back-to-back: o_gen_run stays 1, so the generator's gap counting continues).
    - Otherwise go to IDLE and drop o_gen_run.
- Timeout
  - A 16-bit wait counter clears on entry to WAIT_START and WAIT_END and increments every cycle in those states.
  - When it reaches TIMEOUT_CYCLES-1:
    - o_err = 1, o_gen_run = 0, o_grant = 0.
    - Go to IDLE. The frame is not counted.
- Source behaviour after grant
  - i_req of the granted source is ignored until the frame ends.
  - A source that drops i_req after o_ack does not abort the frame.
  - A source must deassert i_req on o_ack to avoid being rescheduled when its turn returns.
- Stability: o_gen_* and o_grant change only in GRANT, on timeout, or on return to IDLE. They are constant through WAIT_START/WAIT_END.

## Timing
- Reset values
  - State IDLE, rr_ptr 0.
  - o_grant, o_ack, o_done, o_err, o_busy, o_gen_run: 0.
  - o_gen_payload_length, o_gen_mode, o_gen_intergap: 0.
  - o_frame_count 0; wait counter 0.
- All outputs are registered.
- Latency: i_req seen in IDLE at cycle t gives GRANT outputs (o_ack, o_grant, o_gen_*, o_gen_run) at t+1.
- i_gen_txvalid is sampled as a level each cycle. A rise already present in the first WAIT_START cycle moves the FSM to WAIT_END at the next edge.
- Completion: txvalid low at cycle t gives o_done and the count increment at t+1.
  - With a request pending, the next GRANT is at t+1 and o_done coincides with the new o_ack.
- Simultaneous timeout and txvalid edge in the same cycle: the edge wins and no error is raised.
- Asynchronous reset mid-frame returns all outputs to reset values immediately. o_gen_run low forces the generator idle.

## Test plan
- Single frame
  - Stimulus: i_req=0001, length 46, mode 0, gap 12; model txvalid high 8 cycles.
  - Required: o_ack[0] at t+1, o_grant=0001 held, o_done one cycle after txvalid falls, o_frame_count=1, o_gen_run falls.
- Round-robin
  - Stimulus: i_req=1111 held, each frame completes.
  - Required: grants in order 0,1,2,3,0; o_gen_run stays high throughout; o_done and o_ack coincide.
- Reject
  - Stimulus: source 2 length 1501, i_req=0100.
  - Required: o_ack[2] and o_err in the same cycle, o_gen_run stays 0, count unchanged, rr_ptr=3.
- Timeout
  - Stimulus: TIMEOUT_CYCLES=16, txvalid held 0 after grant.
  - Required: o_err exactly 16 cycles after WAIT_START entry, o_gen_run=0, state IDLE, count 0.
- Mid-frame reset
  - Stimulus: assert i_rst_n=0 during WAIT_END.
  - Required: all outputs 0 immediately; after release with i_req=0010, grant goes to source 1 (rr_ptr reset to 0).
- Request drop
  - Stimulus: source 1 drops i_req one cycle after o_ack.
  - Required: frame completes normally, o_done asserted, no further grant to source 1.
